bnn_input_loader: RTL

BNN_INPUT_LOADER -- requirements
Module: bnn_input_loader

---
 rtl/bnn_input_loader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/bnn_input_loader.sv
// Byte-serial loader for one BNN frame: 9-bit kernel, threshold, then the bit-packed 28x28 image into a zero-padded buffer.
// Accepts one byte per cycle; buf_valid the cycle after the last image byte; in_ready low while holding until out_ack.
module bnn_input_loader #(
    parameter int IMG_WIDTH  = 30,
    parameter int KERNEL_LEN = 3
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [7:0]                                   in_data,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic                                         frame_abort,
    input  logic                                         out_ack,
    output logic [IMG_WIDTH*IMG_WIDTH-1:0]               img_buf,
    output logic [KERNEL_LEN*KERNEL_LEN-1:0]             kernel_buf,
    output logic [$clog2(KERNEL_LEN*KERNEL_LEN+1)-1:0]   threshold,
    output logic                                         buf_valid
);

    localparam int IN_LEN          = IMG_WIDTH - 2;
    localparam int IN_SIZE         = IN_LEN * IN_LEN;
    localparam int NBYTES          = (IN_SIZE + 7) / 8;
    localparam int KERNEL_SIZE     = KERNEL_LEN * KERNEL_LEN;
    localparam int THRESHOLD_WIDTH = $clog2(KERNEL_SIZE + 1);
    localparam int KBYTES          = (KERNEL_SIZE + 7) / 8;
    localparam int BC_W            = $clog2(NBYTES + 1);
    localparam int RC_W            = $clog2(IN_LEN + 1);
    localparam int IDX_W           = $clog2(IN_SIZE);

    typedef enum logic [1:0] {
        LD_KERNEL = 2'd0,
        LD_THRESH = 2'd1,
        LD_IMG    = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [BC_W-1:0]              byte_cnt;
    logic [RC_W-1:0]              row;
    logic [RC_W-1:0]              col;
    logic [RC_W-1:0]              row_nxt;
    logic [RC_W-1:0]              col_nxt;
    logic [IN_SIZE-1:0]           pix_q;
    logic [KERNEL_SIZE-1:0]       kernel_q;
    logic [THRESHOLD_WIDTH-1:0]   thresh_q;
    logic [IDX_W-1:0]             pidx [8];
    logic                         pen  [8];
    logic                         accept;
    logic                         last_kbyte;
    logic                         last_ibyte;

    assign accept     = in_valid && in_ready && !frame_abort;
    assign last_kbyte = (byte_cnt == BC_W'(KBYTES - 1));
    assign last_ibyte = (byte_cnt == BC_W'(NBYTES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LD_KERNEL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort wins over everything, including out_ack in HOLD
    always_comb begin
        state_nxt = state;
        if (frame_abort) begin
            state_nxt = LD_KERNEL;
        end else begin
            case (state)
                LD_KERNEL: if (accept && last_kbyte) state_nxt = LD_THRESH;
                LD_THRESH: if (accept)               state_nxt = LD_IMG;
                LD_IMG:    if (accept && last_ibyte) state_nxt = HOLD;
                HOLD:      if (out_ack)              state_nxt = LD_KERNEL;
                default:                             state_nxt = LD_KERNEL;
            endcase
        end
    end

    // Output logic
    always_comb begin
        in_ready  = (state != HOLD);
        buf_valid = (state == HOLD);
    end

    // Walk the 8 pixels of the current byte from (row,col), wrapping columns into rows
    always_comb begin
        logic [RC_W-1:0] rr;
        logic [RC_W-1:0] cc;
        rr = row;
        cc = col;
        for (int b = 0; b < 8; b++) begin
            pen[b]  = (rr < RC_W'(IN_LEN));
            pidx[b] = IDX_W'(IDX_W'(rr) * IDX_W'(IN_LEN) + IDX_W'(cc));
            if (cc == RC_W'(IN_LEN - 1)) begin
                cc = '0;
                if (pen[b]) begin
                    rr = rr + RC_W'(1);
                end
            end else begin
                cc = cc + RC_W'(1);
            end
        end
        row_nxt = rr;
        col_nxt = cc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            row      <= '0;
            col      <= '0;
        end else if (frame_abort || (state == HOLD && out_ack)) begin
            byte_cnt <= '0;
            row      <= '0;
            col      <= '0;
        end else if (accept) begin
            case (state)
                LD_KERNEL: byte_cnt <= last_kbyte ? '0 : byte_cnt + BC_W'(1);
                LD_IMG: begin
                    if (last_ibyte) begin
                        byte_cnt <= '0;
                        row      <= '0;
                        col      <= '0;
                    end else begin
                        byte_cnt <= byte_cnt + BC_W'(1);
                        row      <= row_nxt;
                        col      <= col_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_q <= '0;
        end else if (accept && state == LD_IMG) begin
            for (int b = 0; b < 8; b++) begin
                if (pen[b]) begin
                    pix_q[pidx[b]] <= in_data[b];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            thresh_q <= '0;
        end else if (accept && state == LD_THRESH) begin
            thresh_q <= in_data[THRESHOLD_WIDTH-1:0];
        end
    end

    for (genvar k = 0; k < KERNEL_SIZE; k++) begin : g_kernel
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                kernel_q[k] <= 1'b0;
            end else if (accept && state == LD_KERNEL && byte_cnt == BC_W'(k / 8)) begin
                kernel_q[k] <= in_data[k % 8];
            end
        end
    end

    // Border positions are tied off; only interior positions come from storage
    for (genvar i = 0; i < IMG_WIDTH * IMG_WIDTH; i++) begin : g_img
        localparam int R = i / IMG_WIDTH;
        localparam int C = i % IMG_WIDTH;
        if (R == 0 || R == IMG_WIDTH - 1 || C == 0 || C == IMG_WIDTH - 1) begin : g_border
            assign img_buf[i] = 1'b0;
        end else begin : g_interior
            assign img_buf[i] = pix_q[(R - 1) * IN_LEN + (C - 1)];
        end
    end

    assign kernel_buf = kernel_q;
    assign threshold  = thresh_q;

endmodule
